// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into 32-bit words.
// Stage 1 registers the field bundle and range-checks the immediate.
// Stage 2 assembles the word. Each word leaving the encoder is tagged with an
// auto-incrementing byte address.
module instr_encoder #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [15:0]       count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Stage 1 state
  logic        s1_valid_reg;
  logic [2:0]  s1_fmt_reg;
  logic [6:0]  s1_opcode_reg;
  logic [4:0]  s1_rd_reg;
  logic [4:0]  s1_rs1_reg;
  logic [4:0]  s1_rs2_reg;
  logic [2:0]  s1_funct3_reg;
  logic [6:0]  s1_funct7_reg;
  logic [31:0] s1_imm_reg;
  logic        s1_err_reg;
  logic        s1_shift_reg;

  // Stage 2 / output state
  logic              out_valid_reg;
  logic [31:0]       out_instr_reg;
  logic              out_err_reg;
  logic              err_sticky_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic [15:0]       count_reg;

  logic        s2_adv;
  logic        s1_adv;
  logic        out_xfer;
  logic        in_xfer;
  logic        shift_next;
  logic        err_next;
  logic [31:0] word_next;

  assign s2_adv   = !out_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;
  assign in_xfer  = in_valid && s1_adv;
  assign out_xfer = out_valid_reg && out_ready;

  // Immediate range check on the incoming bundle; a sign-extended value fits
  // in N bits when all bits from N-1 upward agree.
  always_comb begin
    shift_next = (in_fmt == FMT_I) && (in_opcode == 7'b0010011) &&
                 ((in_funct3 == 3'd1) || (in_funct3 == 3'd5));
    err_next = 1'b0;
    case (in_fmt)
      FMT_R: err_next = 1'b0;
      FMT_I: begin
        if (shift_next) err_next = (in_imm[31:5] != '0);
        else            err_next = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FMT_S: err_next = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      FMT_B: err_next = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      FMT_U: err_next = (in_imm[11:0] != '0);
      FMT_J: err_next = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      default: err_next = 1'b1;
    endcase
  end

  // Stage 1 register: captures a bundle whenever the slot is free or moving on
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_xfer) begin
        s1_fmt_reg    <= in_fmt;
        s1_opcode_reg <= in_opcode;
        s1_rd_reg     <= in_rd;
        s1_rs1_reg    <= in_rs1;
        s1_rs2_reg    <= in_rs2;
        s1_funct3_reg <= in_funct3;
        s1_funct7_reg <= in_funct7;
        s1_imm_reg    <= in_imm;
        s1_err_reg    <= err_next;
        s1_shift_reg  <= shift_next;
      end
    end
  end

  // Word assembly from stage 1 fields; out-of-range immediates are simply truncated
  always_comb begin
    word_next = NOP_WORD;
    case (s1_fmt_reg)
      FMT_R: word_next = {s1_funct7_reg, s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                          s1_rd_reg, s1_opcode_reg};
      FMT_I: begin
        if (s1_shift_reg)
          word_next = {s1_funct7_reg, s1_imm_reg[4:0], s1_rs1_reg, s1_funct3_reg,
                       s1_rd_reg, s1_opcode_reg};
        else
          word_next = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg,
                       s1_rd_reg, s1_opcode_reg};
      end
      FMT_S: word_next = {s1_imm_reg[11:5], s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                          s1_imm_reg[4:0], s1_opcode_reg};
      FMT_B: word_next = {s1_imm_reg[12], s1_imm_reg[10:5], s1_rs2_reg, s1_rs1_reg,
                          s1_funct3_reg, s1_imm_reg[4:1], s1_imm_reg[11], s1_opcode_reg};
      FMT_U: word_next = {s1_imm_reg[31:12], s1_rd_reg, s1_opcode_reg};
      FMT_J: word_next = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                          s1_imm_reg[19:12], s1_rd_reg, s1_opcode_reg};
      default: word_next = NOP_WORD;
    endcase
  end

  // Stage 2 register: holds the word stable while the consumer stalls
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= '0;
      out_err_reg   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_instr_reg <= word_next;
        out_err_reg   <= s1_err_reg;
      end
    end
  end

  // Address tag, transfer count and sticky error, all advanced by output transfers
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_addr_reg   <= '0;
      count_reg      <= '0;
      err_sticky_reg <= 1'b0;
    end else begin
      if (addr_load)     out_addr_reg <= addr_in;
      else if (out_xfer) out_addr_reg <= out_addr_reg + ADDR_W'(4);
      if (out_xfer)                count_reg      <= count_reg + 16'd1;
      if (out_xfer && out_err_reg) err_sticky_reg <= 1'b1;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_instr  = out_instr_reg;
  assign out_err    = out_err_reg;
  assign out_addr   = out_addr_reg;
  assign err_sticky = err_sticky_reg;
  assign count      = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios followed by random bundles,
// all words checked against an arithmetic reference encoder and scoreboard.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [11:0] out_addr;
  logic        out_err;
  logic        err_sticky;
  logic        addr_load = 1'b0;
  logic [11:0] addr_in = '0;
  logic [15:0] count;

  instr_encoder #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky),
    .addr_load(addr_load), .addr_in(addr_in), .count(count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  typedef struct packed { logic err; logic [31:0] word; } exp_t;
  exp_t        q[$];
  logic [11:0] exp_addr = '0;
  logic [15:0] exp_count = '0;
  logic        exp_sticky = 1'b0;
  logic        have_stall = 1'b0;
  logic [31:0] stall_instr = '0;
  logic [11:0] stall_addr = '0;
  bit          rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder written from the ISA field layout with plain arithmetic.
  function automatic exp_t ref_enc(input logic [2:0] fmt, input logic [6:0] op,
                                   input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] imm);
    exp_t r;
    int signed   v = int'(imm);
    logic [31:0] common = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    r.err = 1'b0;
    case (fmt)
      3'd0: r.word = (32'(f7) << 25) | (32'(rs2) << 20) | common | (32'(rd) << 7);
      3'd1: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          r.word = (32'(f7) << 25) | ((imm % 32) << 20) | common | (32'(rd) << 7);
          r.err  = (v < 0) || (v > 31);
        end else begin
          r.word = ((imm % 4096) << 20) | common | (32'(rd) << 7);
          r.err  = (v < -2048) || (v > 2047);
        end
      end
      3'd2: begin
        r.word = (((imm / 32) % 128) << 25) | (32'(rs2) << 20) | common | ((imm % 32) << 7);
        r.err  = (v < -2048) || (v > 2047);
      end
      3'd3: begin
        r.word = (((imm / 4096) % 2) << 31) | (((imm / 32) % 64) << 25) | (32'(rs2) << 20) |
                 common | (((imm / 2) % 16) << 8) | (((imm / 2048) % 2) << 7);
        r.err  = (v < -4096) || (v > 4094) || (imm % 2 != 0);
      end
      3'd4: begin
        r.word = (imm - (imm % 4096)) | (32'(rd) << 7) | 32'(op);
        r.err  = (imm % 4096) != 0;
      end
      3'd5: begin
        r.word = (((imm / 1048576) % 2) << 31) | (((imm / 2) % 1024) << 21) |
                 (((imm / 2048) % 2) << 20) | (((imm / 4096) % 256) << 12) |
                 (32'(rd) << 7) | 32'(op);
        r.err  = (v < -1048576) || (v > 1048574) || (imm % 2 != 0);
      end
      default: begin
        r.word = 32'h0000_0013;
        r.err  = 1'b1;
      end
    endcase
    return r;
  endfunction

  // Drive one bundle and hold it until accepted; the scoreboard entry is queued
  // on the cycle the transfer takes place.
  task automatic push(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    int  waited = 0;
    bit  done = 0;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(ref_enc(fmt, op, rd, rs1, rs2, f3, f7, imm));
        done = 1;
      end else if (++waited > 300) begin
        check("push_timeout", 32'(in_ready), 32'd1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while ((q.size() != 0 || out_valid) && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  // Random consumer back-pressure
  always @(posedge clk) if (rnd_ready) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: checks each transferred word, its address, count, sticky
  // flag, and that a stalled word holds still.
  always @(negedge clk) begin
    exp_t e;
    bit   xfer;
    if (!reset) begin
      q.delete();
      exp_addr = '0; exp_count = '0; exp_sticky = 1'b0; have_stall = 1'b0;
    end else begin
      if (have_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_instr", out_instr, stall_instr);
        check("hold_addr", 32'(out_addr), 32'(stall_addr));
      end
      xfer = out_valid && out_ready;
      if (xfer) begin
        if (q.size() == 0) begin
          check("spurious_word", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("word", out_instr, e.word);
          check("err", 32'(out_err), 32'(e.err));
          check("addr", 32'(out_addr), 32'(exp_addr));
          check("count", 32'(count), 32'(exp_count));
          check("sticky", 32'(err_sticky), 32'(exp_sticky));
          if (e.err) exp_sticky = 1'b1;
        end
        exp_count = exp_count + 16'd1;
      end
      if (addr_load) exp_addr = addr_in;
      else if (xfer) exp_addr = exp_addr + 12'd4;
      have_stall  = out_valid && !out_ready;
      stall_instr = out_instr;
      stall_addr  = out_addr;
    end
  end

  initial begin
    int bnd[18] = '{-1048577, -1048576, 1048574, 1048575, -4097, -4096, 4094, 4095,
                    -2049, -2048, 2047, 2048, 0, 31, 32, -1, 4096, 8192};
    logic [2:0]  rf;
    logic [6:0]  rop;
    logic [2:0]  rf3;
    logic [31:0] rimm;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // ADD x3,x1,x2: valid appears on the second edge after the input transfer
    push(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("add_word", out_instr, 32'h002081B3);
    check("add_addr", 32'(out_addr), 32'd0);
    wait_drain();

    // ADDI x1,x0,-1 then BEQ x1,x2,+8 back to back
    push(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    push(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    check("addi_word", out_instr, 32'hFFF00093);
    check("addi_err", 32'(out_err), 32'd0);
    @(posedge clk); #1;
    check("beq_word", out_instr, 32'h00208463);
    check("beq_addr", 32'(out_addr), 32'd8);
    wait_drain();

    // Errored words: sticky sets only on transfer
    out_ready = 1'b0;
    push(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    @(posedge clk); #1;
    check("j_err_flag", 32'(out_err), 32'd1);
    check("sticky_pre_xfer", 32'(err_sticky), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("sticky_post_xfer", 32'(err_sticky), 32'd1);
    push(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    push(3'd7, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    check("i2048_err", 32'(out_err), 32'd1);
    @(posedge clk); #1;
    check("illegal_nop", out_instr, 32'h00000013);
    check("illegal_err", 32'(out_err), 32'd1);
    wait_drain();

    // Back-pressure: two words fill the pipe
    do_reset();
    out_ready = 1'b0;
    push(3'd0, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0);
    push(3'd2, 7'h23, 5'd0, 5'd6, 5'd7, 3'd2, 7'd0, 32'hFFFF_F800);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    push(3'd4, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    wait_drain();
    check("count_three", 32'(count), 32'd3);
    check("addr_after_three", 32'(out_addr), 32'd12);

    // Address load coinciding with a transfer, then wrap at the top
    push(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1);
    @(posedge clk); #1 addr_load = 1'b1; addr_in = 12'h100;
    @(posedge clk); #1 addr_load = 1'b0;
    check("load_addr", 32'(out_addr), 32'h100);
    check("load_count", 32'(count), 32'd4);
    addr_load = 1'b1; addr_in = 12'hFFC;
    @(posedge clk); #1 addr_load = 1'b0;
    push(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd5, 7'h20, 32'd31);
    wait_drain();
    check("wrap_addr", 32'(out_addr), 32'h000);

    // Reset with two words in flight
    out_ready = 1'b0;
    push(3'd0, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    push(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    do_reset();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_sticky", 32'(err_sticky), 32'd0);
    out_ready = 1'b1;
    push(3'd4, 7'h17, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
    @(posedge clk); #1;
    check("post_rst_addr", 32'(out_addr), 32'd0);
    wait_drain();

    // Random bundles with random consumer stalls
    rnd_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      rf  = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      rop = 7'($urandom);
      rf3 = 3'($urandom);
      if (rf == 3'd1 && $urandom_range(0, 1) == 1) begin
        rop = 7'h13;
        rf3 = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
      end
      case ($urandom_range(0, 3))
        0: rimm = $urandom;
        1: rimm = 32'(bnd[$urandom_range(0, 17)]);
        2: rimm = 32'($urandom_range(0, 200)) - 32'd100;
        default: rimm = $urandom & 32'hFFFF_F000;
      endcase
      push(rf, rop, 5'($urandom), 5'($urandom), 5'($urandom), rf3, 7'($urandom), rimm);
    end
    rnd_ready = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    wait_drain();
    check("final_count", 32'(count), 32'(exp_count));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
